// File: rtl/matrixmul_stage_sequencer.sv
// matrixmul_stage_sequencer: runs the enabled matrixmul sub-loops one after another over ap_ctrl_hs, with a per-stage watchdog and a run-latency counter
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   ap_start/idle/ready/done top-level ap_ctrl_hs handshake
//   stage_mask              stages to run, sampled when a run is accepted
//   stage_start/ready/done  per-stage ap_ctrl_hs handshake, stage_start is one-hot
//   err_timeout, err_stage  sticky watchdog flag and the index of the stage that expired
//   total_cycles            accept-to-done latency of the last run, saturating
module matrixmul_stage_sequencer #(
   parameter int N_STAGES = 5,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                ap_start,
   input  logic [N_STAGES-1:0] stage_mask,
   output logic                ap_idle,
   output logic                ap_ready,
   output logic                ap_done,
   output logic [N_STAGES-1:0] stage_start,
   input  logic [N_STAGES-1:0] stage_ready,
   input  logic [N_STAGES-1:0] stage_done,
   output logic                err_timeout,
   output logic [2:0]          err_stage,
   output logic [CNT_W-1:0]    total_cycles
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ERR} state_t;
   state_t              state_q;
   logic [N_STAGES-1:0] mask_q;
   logic [N_STAGES-1:0] start_q;
   logic [2:0]          stage_q;
   logic [2:0]          err_stage_q;
   logic [CNT_W-1:0]    wd_q;
   logic [CNT_W-1:0]    tot_q;
   logic                idle_q;
   logic                done_q;
   logic                err_q;
   logic [3:0]          first_d;
   logic [3:0]          next_d;
   logic                cur_done;
   logic                cur_ready;
   logic [CNT_W-1:0]    tot_inc;
   // lowest set bit of m at or above lo, as {valid, index}
   function automatic logic [3:0] pick(input logic [N_STAGES-1:0] m, input int lo);
      pick = '0;
      for (int i = N_STAGES - 1; i >= 0; i--)
         if (m[i] && i >= lo) pick = {1'b1, 3'(i)};
   endfunction
   always_comb begin
      first_d   = pick(stage_mask, 0);
      next_d    = pick(mask_q, int'(stage_q) + 1);
      cur_done  = stage_done[stage_q];
      cur_ready = stage_ready[stage_q];
      tot_inc   = &tot_q ? tot_q : tot_q + 1'b1;
   end
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         start_q     <= '0;
         stage_q     <= '0;
         err_stage_q <= '0;
         wd_q        <= '0;
         tot_q       <= '0;
         idle_q      <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // the IDLE cycle carrying ap_done still reports busy and never accepts
               if (done_q) idle_q <= 1'b1;
               else if (ap_start) begin
                  mask_q      <= stage_mask;
                  err_q       <= 1'b0;
                  err_stage_q <= '0;
                  tot_q       <= 1'b1;
                  idle_q      <= 1'b0;
                  if (first_d[3]) begin
                     state_q <= LAUNCH;
                     stage_q <= first_d[2:0];
                     start_q <= N_STAGES'(1) << first_d[2:0];
                     wd_q    <= 1'b1;
                  end else done_q <= 1'b1;
               end
            end
            LAUNCH, WAIT: begin
               tot_q <= tot_inc;
               // done beats both ready and an expiring watchdog in the same cycle
               if (cur_done) begin
                  if (next_d[3]) begin
                     state_q <= LAUNCH;
                     stage_q <= next_d[2:0];
                     start_q <= N_STAGES'(1) << next_d[2:0];
                     wd_q    <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     start_q <= '0;
                     done_q  <= 1'b1;
                  end
               end else if (wd_q == CNT_W'(TIMEOUT)) begin
                  state_q     <= ERR;
                  start_q     <= '0;
                  done_q      <= 1'b1;
                  err_q       <= 1'b1;
                  err_stage_q <= stage_q;
               end else begin
                  wd_q <= wd_q + 1'b1;
                  if (state_q == LAUNCH && cur_ready) begin
                     state_q <= WAIT;
                     start_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end
   assign ap_idle      = idle_q;
   assign ap_ready     = done_q;
   assign ap_done      = done_q;
   assign stage_start  = start_q;
   assign err_timeout  = err_q;
   assign err_stage    = err_stage_q;
   assign total_cycles = tot_q;
endmodule
